// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM encoding and default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  localparam int SPI_LENGTH = 8;
  localparam int SPI_NREQ   = 4;
  localparam int SPI_DIV    = 2;

  // Rising Sclk edges per frame: one slave dummy edge plus one per data bit.
  function automatic int frame_edges(input int len);
    return len + 1;
  endfunction

  localparam int SPI_FRAME_EDGES = frame_edges(SPI_LENGTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin pick: first set req bit at or after the pointer, wrapping around.
// Latency: purely combinational.
// Backpressure: none; caller samples the pick only when it can accept a new owner.
module spi_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            vld_o
);

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    int idx;
    logic [PW-1:0] sel;
    gnt_o = '0;
    vld_o = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PW'(idx);
      if (!vld_o && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin SPI master sharing one Sclk/Mosi/Miso bus; one LSB-first frame per grant.
// Latency: grant 1 clk after req seen in IDLE; Cs low DIV + 2*DIV*(LENGTH+1) + DIV clks per frame.
// Backpressure: req is a held level; requests arriving mid-frame wait for IDLE.
// Optional feature macro: SPI_ARB_LOCK_EN (lock input keeps the owner's Cs low across frames).
module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int LENGTH = SPI_LENGTH,
  parameter int NREQ   = SPI_NREQ,
  parameter int DIV    = SPI_DIV,
  parameter int CNT_W  = $clog2(SPI_FRAME_EDGES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*LENGTH-1:0] tx_data,
`ifdef SPI_ARB_LOCK_EN
  input  logic [NREQ-1:0]        lock,
`endif
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   done,
  output logic [LENGTH-1:0]      rx_data,
  output logic                   Sclk,
  output logic                   Mosi,
  input  logic                   Miso,
  output logic [NREQ-1:0]        Cs
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EDGES = frame_edges(LENGTH);

  spi_state_e        state_q;
  logic [PW-1:0]     ptr_q, owner_q;
  logic [NREQ-1:0]   grant_q, cs_q;
  logic              busy_q, done_q, sclk_q, mosi_q, relock_q;
  logic [LENGTH-1:0] tx_sh_q, rx_sh_q, rx_q;
  logic [HW-1:0]     hp_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;

  logic [NREQ-1:0]   pick_oh;
  logic              pick_vld;
  logic [PW-1:0]     pick_idx;
  logic [LENGTH-1:0] pick_word, own_word;
  logic              relock_d;
  logic              hp_wrap;

  spi_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh),
    .vld_o (pick_vld)
  );

  // Decode the winning index and select the words for a new grant and a re-grant.
  always_comb begin
    pick_idx  = '0;
    pick_word = '0;
    own_word  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx  = PW'(i);
        pick_word = tx_data[i*LENGTH +: LENGTH];
      end
      if (owner_q == PW'(i)) own_word = tx_data[i*LENGTH +: LENGTH];
    end
  end

`ifdef SPI_ARB_LOCK_EN
  assign relock_d = lock[owner_q] & req[owner_q];
`else
  assign relock_d = 1'b0;
`endif

  assign hp_wrap = (hp_cnt_q == HW'(DIV - 1));

  // Frame sequencer: owns every registered output, Sclk generation and both shifters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      cs_q       <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      relock_q   <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_q       <= '0;
      hp_cnt_q   <= '0;
      edge_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            owner_q    <= pick_idx;
            grant_q    <= pick_oh;
            cs_q       <= ~pick_oh;
            busy_q     <= 1'b1;
            tx_sh_q    <= pick_word;
            hp_cnt_q   <= '0;
            edge_cnt_q <= '0;
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (hp_wrap) begin
            hp_cnt_q <= '0;
            state_q  <= ST_XFER;
          end else begin
            hp_cnt_q <= hp_cnt_q + 1'b1;
          end
        end
        ST_XFER: begin
          if (hp_wrap) begin
            hp_cnt_q <= '0;
            sclk_q   <= ~sclk_q;
            if (!sclk_q) begin
              // Rising edge: the first one is the slave's dummy edge, no sample.
              edge_cnt_q <= edge_cnt_q + 1'b1;
              if (edge_cnt_q != '0) rx_sh_q <= {Miso, rx_sh_q[LENGTH-1:1]};
            end else begin
              // Falling edge k drives tx bit k-1; the last falling edge ends the data phase.
              if (edge_cnt_q <= CNT_W'(LENGTH)) begin
                mosi_q  <= tx_sh_q[0];
                tx_sh_q <= tx_sh_q >> 1;
              end
              if (edge_cnt_q == CNT_W'(EDGES)) state_q <= ST_HOLD;
            end
          end else begin
            hp_cnt_q <= hp_cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (hp_wrap) begin
            hp_cnt_q <= '0;
            done_q   <= 1'b1;
            rx_q     <= rx_sh_q;
            relock_q <= relock_d;
            state_q  <= ST_DONE;
            if (!relock_d) begin
              cs_q    <= '1;
              grant_q <= '0;
              busy_q  <= 1'b0;
              ptr_q   <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            end
          end else begin
            hp_cnt_q <= hp_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (relock_q) begin
            tx_sh_q    <= own_word;
            hp_cnt_q   <= '0;
            edge_cnt_q <= '0;
            state_q    <= ST_SETUP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign Sclk    = sclk_q;
  assign Mosi    = mosi_q;
  assign Cs      = cs_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a behavioural LSB-first slave on the shared bus.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_bus_arbiter;

  localparam int L = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*L-1:0] tx_data;
`ifdef SPI_ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif
  logic [N-1:0]   grant;
  logic           busy, done;
  logic [L-1:0]   rx_data;
  logic           Sclk, Mosi;
  logic           Miso = 1'b0;
  logic [N-1:0]   Cs;

  spi_bus_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .tx_data (tx_data),
`ifdef SPI_ARB_LOCK_EN
    .lock    (lock),
`endif
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .Sclk    (Sclk),
    .Mosi    (Mosi),
    .Miso    (Miso),
    .Cs      (Cs)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Bus observer and slave model state.
  int           cs_run = 0, gap_run = 0, min_gap = 99;
  int           last_low_len = 0, last_rises = 0, slv_edge = 0;
  int           mosi_chg = 0, mosi_chg_last = 0, done_cnt = 0, cs_bad = 0, dc0 = 0;
  logic [L-1:0] d_rec = '0, d_last = '0, slv_sh = '0, slv_din = '0;
  logic         force_en = 1'b0, force_val = 1'b0;
  logic         sclk_prev = 1'b0, mosi_prev = 1'b0, cs_prev_all = 1'b1;
  logic [N-1:0] grant_prev = '0;
  logic [N-1:0] gq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (done !== 1'b1 && k < budget);
    check({tag, "_done_seen"}, 32'(done === 1'b1), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (busy !== 1'b1 && k < budget);
    check({tag, "_busy_seen"}, 32'(busy === 1'b1), 32'd1);
  endtask

  // Slave: dummy first rising edge, samples Mosi on edges 2..L+1, drives Miso after falls 1..L.
  always @(negedge clk) begin
    if (!(&Cs)) begin
      cs_run++;
    end else begin
      if (cs_run != 0) begin
        last_low_len = cs_run;
        last_rises   = slv_edge;
      end
      cs_run = 0;
    end
    if (&Cs) begin
      gap_run++;
    end else begin
      if (gap_run != 0 && gap_run < min_gap) min_gap = gap_run;
      gap_run = 0;
    end
    if ((!(&Cs) && cs_prev_all) || done === 1'b1) begin
      slv_edge = 0;
      d_rec    = '0;
      slv_sh   = slv_din;
      mosi_chg = 0;
    end else if (!(&Cs)) begin
      if (Sclk && !sclk_prev) begin
        slv_edge++;
        if (slv_edge >= 2 && slv_edge <= L + 1) d_rec = {Mosi, d_rec[L-1:1]};
        if (slv_edge == L + 1) begin
          d_last        = d_rec;
          mosi_chg_last = mosi_chg;
        end
      end else if (!Sclk && sclk_prev) begin
        if (slv_edge >= 1 && slv_edge <= L) begin
          Miso   = slv_sh[0];
          slv_sh = slv_sh >> 1;
        end
      end
      if (slv_edge >= 2 && Mosi !== mosi_prev) mosi_chg++;
    end
    if (force_en) Miso = force_val;
    if (done === 1'b1) done_cnt++;
    if ($countones(~Cs) > 1) cs_bad++;
    if (grant != '0 && grant_prev == '0) gq.push_back(grant);
    grant_prev  = grant;
    mosi_prev   = Mosi;
    sclk_prev   = Sclk;
    cs_prev_all = &Cs;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed still running, required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = '0; tx_data = '0;
`ifdef SPI_ARB_LOCK_EN
    lock = '0;
`endif
    @(negedge clk); #1;
    check("rst_cs", 32'(Cs), 32'hF);
    check("rst_sclk", 32'(Sclk), 32'd0);
    check("rst_mosi", 32'(Mosi), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", 32'(rx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Single frame, requester 0; tx_data change after grant must be ignored.
    slv_din = 8'h3C; tx_data[7:0] = 8'hA5; dc0 = done_cnt;
    req = 4'b0001;
    @(negedge clk); #1;
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_cs", 32'(Cs), 32'hE);
    tx_data[7:0] = 8'h00;
    wait_done("t1", 200);
    req = '0;
    check("t1_rx", 32'(rx_data), 32'h3C);
    check("t1_cs_len", 32'(last_low_len), 32'd40);
    check("t1_rises", 32'(last_rises), 32'd9);
    check("t1_slave_rec", 32'(d_last), 32'hA5);
    check("t1_grant_done", 32'(grant), 32'd0);
    @(negedge clk); #1;
    check("t1_done_pulse", 32'(done), 32'd0);
    repeat (3) begin @(negedge clk); #1; end
    check("t1_done_cnt", 32'(done_cnt - dc0), 32'd1);

    // Round-robin from a fresh pointer with req=1011 held.
    rst = 1'b1; @(negedge clk); #1; rst = 1'b0;
    gq.delete(); min_gap = 99;
    req = 4'b1011;
    for (int f = 0; f < 4; f++) wait_done("rr", 200);
    req = '0;
    check("rr_count", 32'(gq.size()), 32'd4);
    check("rr_g0", 32'(gq[0]), 32'h1);
    check("rr_g1", 32'(gq[1]), 32'h2);
    check("rr_g2", 32'(gq[2]), 32'h8);
    check("rr_g3", 32'(gq[3]), 32'h1);
    check("rr_gap_ge2", 32'(min_gap >= 2), 32'd1);
    repeat (3) begin @(negedge clk); #1; end

    // Late request from requester 2 while requester 0 is mid-frame.
    gq.delete(); min_gap = 99;
    req = 4'b0001;
    wait_busy("late0", 10);
    repeat (10) begin @(negedge clk); #1; end
    req = 4'b0101;
    repeat (3) begin @(negedge clk); #1; end
    check("late_grant_hold", 32'(grant), 32'h1);
    check("late_cs_hold", 32'(Cs), 32'hE);
    wait_done("late0", 200);
    req = 4'b0100;
    wait_busy("late2", 10);
    check("late_grant2", 32'(grant), 32'h4);
    check("late_cs2", 32'(Cs), 32'hB);
    wait_done("late2", 200);
    req = '0;
    check("late_order", 32'(gq.size()), 32'd2);
    check("late_gap_ge2", 32'(min_gap >= 2), 32'd1);
    repeat (3) begin @(negedge clk); #1; end

    // Reset at the 5th Sclk rising edge, then a clean frame.
    tx_data[7:0] = 8'hFF;
    req = 4'b0001;
    begin
      int k;
      k = 0;
      while (slv_edge < 5 && k < 200) begin @(negedge clk); #1; k++; end
      check("mid_edge5_seen", 32'(slv_edge), 32'd5);
    end
    rst = 1'b1; #1;
    check("mid_cs", 32'(Cs), 32'hF);
    check("mid_sclk", 32'(Sclk), 32'd0);
    check("mid_mosi", 32'(Mosi), 32'd0);
    check("mid_grant", 32'(grant), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rx", 32'(rx_data), 32'd0);
    repeat (2) begin @(negedge clk); #1; end
    slv_din = 8'h96; tx_data[7:0] = 8'h5A;
    rst = 1'b0;
    wait_done("mid_after", 200);
    req = '0;
    check("mid_after_rx", 32'(rx_data), 32'h96);
    check("mid_after_rec", 32'(d_last), 32'h5A);
    check("mid_after_len", 32'(last_low_len), 32'd40);
    repeat (3) begin @(negedge clk); #1; end

    // Data extremes with Miso pinned.
    force_en = 1'b1; force_val = 1'b1; tx_data[7:0] = 8'h00;
    req = 4'b0001;
    wait_done("ext0", 200);
    req = '0;
    check("ext0_rx", 32'(rx_data), 32'hFF);
    check("ext0_rec", 32'(d_last), 32'h00);
    check("ext0_mosi_chg", 32'(mosi_chg_last), 32'd0);
    repeat (3) begin @(negedge clk); #1; end
    force_val = 1'b0; tx_data[7:0] = 8'hFF;
    req = 4'b0001;
    wait_done("ext1", 200);
    req = '0;
    check("ext1_rx", 32'(rx_data), 32'h00);
    check("ext1_rec", 32'(d_last), 32'hFF);
    check("ext1_mosi_chg", 32'(mosi_chg_last), 32'd0);
    force_en = 1'b0;
    repeat (3) begin @(negedge clk); #1; end

`ifdef SPI_ARB_LOCK_EN
    // Locked requester 1: two frames with Cs[1] held low, then requester 0.
    gq.delete(); slv_din = 8'h77; tx_data[15:8] = 8'hC3; dc0 = done_cnt;
    lock = 4'b0010; req = 4'b0011;
    wait_done("lk1", 200);
    check("lk1_grant", 32'(grant), 32'h2);
    check("lk1_cs", 32'(Cs), 32'hD);
    check("lk1_rx", 32'(rx_data), 32'h77);
    check("lk1_rec", 32'(d_last), 32'hC3);
    lock = '0; tx_data[15:8] = 8'h3C;
    wait_done("lk2", 200);
    check("lk2_rx", 32'(rx_data), 32'h77);
    check("lk2_rec", 32'(d_last), 32'h3C);
    check("lk2_cs_len", 32'(last_low_len), 32'd81);
    check("lk2_done_cnt", 32'(done_cnt - dc0), 32'd2);
    wait_busy("lk3", 10);
    check("lk3_grant", 32'(grant), 32'h1);
    check("lk3_first", 32'(gq[0]), 32'h2);
    wait_done("lk3", 200);
    req = '0;
    repeat (3) begin @(negedge clk); #1; end
`endif

    check("cs_onehot", 32'(cs_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
